// File: rtl/up_pkg.sv
// up_pkg -- shared definitions for the microcoded datapath.
//   Holds the ControlBus bit indices, the control-word width and the default
//   data width, so the controller and microcode tables decode the same word.
//   ctrl_t is the ControlBus word viewed as named fields; its packed layout
//   matches the bit indices below (bit 0 = ldA ... bit 6 = done).
package up_pkg;

  localparam int CW_WIDTH      = 7;
  localparam int DEFAULT_WIDTH = 8;

  localparam int LD_A_BIT   = 0;
  localparam int LD_B_BIT   = 1;
  localparam int DEC_B_BIT  = 2;
  localparam int ADD_AB_BIT = 3;
  localparam int CLR_A_BIT  = 4;
  localparam int LD_OUT_BIT = 5;
  localparam int DONE_BIT   = 6;

  typedef struct packed {
    logic done;   // bit 6
    logic ldOut;  // bit 5
    logic clrA;   // bit 4
    logic addAb;  // bit 3
    logic decB;   // bit 2
    logic ldB;    // bit 1
    logic ldA;    // bit 0
  } ctrl_t;

  function automatic ctrl_t decodeCtrl(input logic [CW_WIDTH-1:0] word);
    return ctrl_t'(word);
  endfunction

endpackage

// File: rtl/up_alu.sv
// up_alu -- combinational adder for the A/B datapath.
//   Ports:
//     A, B   : WIDTH-bit operands (pre-edge register values)
//     sum    : (A + B) mod 2^WIDTH
//     carry  : carry out of bit WIDTH-1
module up_alu
  import up_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // One extra bit on the operands so the carry falls out of the add.
  assign {carry, sum} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/up_datapath.sv
// up_datapath -- register datapath driven by a 7-bit microinstruction word.
//   Ports:
//     clk        : system clock, rising-edge active
//     reset_n    : asynchronous active-low reset
//     ControlBus : microinstruction (see up_pkg for the bit map)
//     din        : operand bus for LD_A / LD_B
//     Z          : combinational (B == 0)
//     C          : sticky carry from ADD_AB, cleared by CLR_A
//     dout       : result register, loaded from A on LD_OUT
//     dout_valid : one-cycle pulse after an LD_OUT edge
//     done       : one-cycle pulse after a DONE edge
//   Every operation on an edge uses pre-edge register values, so any
//   combination of control bits is legal in one word.
module up_datapath
  import up_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CW_WIDTH-1:0] ControlBus,
  input  logic [WIDTH-1:0]    din,
  output logic                Z,
  output logic                C,
  output logic [WIDTH-1:0]    dout,
  output logic                dout_valid,
  output logic                done
);

  ctrl_t            ctl;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] aluSum;
  logic             aluCarry;

  assign ctl = decodeCtrl(ControlBus);

  up_alu #(.WIDTH(WIDTH)) alu (
    .A     (regA),
    .B     (regB),
    .sum   (aluSum),
    .carry (aluCarry)
  );

  // Z comes straight from B so the controller sees the flag produced by the
  // previous edge with no added latency.
  assign Z = (regB == '0);

  // NOTE: non-blocking assignments make every right-hand side read the
  // pre-edge value, which is exactly what lets ADD_AB+DEC_B add the old B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regA       <= '0;
      regB       <= '0;
      C          <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      // A: CLR_A beats LD_A beats ADD_AB.
      if (ctl.clrA)       regA <= '0;
      else if (ctl.ldA)   regA <= din;
      else if (ctl.addAb) regA <= aluSum;

      // B: a load beats a decrement; 0 wraps to all-ones.
      if (ctl.ldB)       regB <= din;
      else if (ctl.decB) regB <= regB - WIDTH'(1);

      // C only sets when the add actually reaches A.
      if (ctl.clrA)                                C <= 1'b0;
      else if (ctl.addAb && !ctl.ldA && aluCarry) C <= 1'b1;

      if (ctl.ldOut) dout <= regA;
      dout_valid <= ctl.ldOut;
      done       <= ctl.done;
    end
  end

endmodule

// File: tb/tb_up_datapath.sv
// tb_up_datapath -- directed bench for up_datapath (WIDTH = 8).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
//   Every LD_OUT pushes its expected dout onto a scoreboard queue, which is
//   popped whenever dout_valid is seen.
module tb_up_datapath;
  import up_pkg::*;

  localparam logic [6:0] NOP    = 7'h00;
  localparam logic [6:0] LD_A   = 7'(1) << LD_A_BIT;
  localparam logic [6:0] LD_B   = 7'(1) << LD_B_BIT;
  localparam logic [6:0] DEC_B  = 7'(1) << DEC_B_BIT;
  localparam logic [6:0] ADD_AB = 7'(1) << ADD_AB_BIT;
  localparam logic [6:0] CLR_A  = 7'(1) << CLR_A_BIT;
  localparam logic [6:0] LD_OUT = 7'(1) << LD_OUT_BIT;
  localparam logic [6:0] DONE   = 7'(1) << DONE_BIT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] ControlBus;
  logic [7:0] din;
  logic       Z, C, dout_valid, done;
  logic [7:0] dout;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ[$];

  up_datapath #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ControlBus (ControlBus),
    .din        (din),
    .Z          (Z),
    .C          (C),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word for one edge, then score any dout_valid it produced.
  task automatic step(input logic [6:0] cw, input logic [7:0] d = 8'h00);
    logic [7:0] exp;
    ControlBus = cw;
    din        = d;
    @(posedge clk);
    #1;
    ControlBus = NOP;
    din        = 8'h00;
    if (dout_valid) begin
      if (expQ.size() == 0) begin
        check("unexpected dout_valid", 32'(dout_valid), 32'h0);
      end else begin
        exp = expQ.pop_front();
        check("dout", 32'(dout), 32'(exp));
      end
    end
  endtask

  task automatic readOut(input logic [7:0] exp);
    expQ.push_back(exp);
    step(LD_OUT);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    ControlBus = NOP;
    din        = 8'h00;
    #12;
    check("reset Z", 32'(Z), 32'h1);
    check("reset C", 32'(C), 32'h0);
    check("reset dout", 32'(dout), 32'h0);
    check("reset dout_valid", 32'(dout_valid), 32'h0);
    check("reset done", 32'(done), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Load and zero flag, including the wrap of B through zero.
    step(LD_B, 8'd3);
    check("Z after LD_B 3", 32'(Z), 32'h0);
    step(DEC_B);
    check("Z at B=2", 32'(Z), 32'h0);
    step(DEC_B);
    check("Z at B=1", 32'(Z), 32'h0);
    step(DEC_B);
    check("Z at B=0", 32'(Z), 32'h1);
    step(DEC_B);
    check("Z at B=FF", 32'(Z), 32'h0);
    step(CLR_A);
    step(ADD_AB);
    readOut(8'hFF);
    check("C after 0+FF", 32'(C), 32'h0);

    // Multiply 4 x 5: B holds the multiplicand, the controller counts five
    // adds, then counts B down to zero before reading the product out.
    step(CLR_A);
    step(LD_B, 8'd4);
    for (int i = 0; i < 5; i++) step(ADD_AB);
    for (int i = 0; i < 4; i++) begin
      check("Z before multiply drain", 32'(Z), 32'h0);
      step(DEC_B);
    end
    check("Z after multiply drain", 32'(Z), 32'h1);
    readOut(8'd20);
    step(NOP);
    check("dout_valid one cycle", 32'(dout_valid), 32'h0);
    check("dout holds", 32'(dout), 32'd20);

    // Carry and priority.
    step(LD_A, 8'hF0);
    step(LD_B, 8'h20);
    step(LD_A | ADD_AB, 8'hF0);
    check("C not set when LD_A wins", 32'(C), 32'h0);
    step(ADD_AB);
    check("C after F0+20", 32'(C), 32'h1);
    readOut(8'h10);
    step(NOP);
    check("C sticky", 32'(C), 32'h1);
    step(CLR_A | LD_A | ADD_AB, 8'h55);
    check("C after CLR_A", 32'(C), 32'h0);
    readOut(8'h00);
    step(LD_B, 8'd2);
    step(LD_A, 8'd7);
    step(ADD_AB | DEC_B);
    readOut(8'd9);
    check("Z at B=1 after ADD+DEC", 32'(Z), 32'h0);
    step(DEC_B);
    check("Z at B=0 after ADD+DEC", 32'(Z), 32'h1);

    // done pulses.
    step(DONE);
    check("done single", 32'(done), 32'h1);
    step(NOP);
    check("done single ends", 32'(done), 32'h0);
    step(DONE);
    check("done pair 1", 32'(done), 32'h1);
    step(DONE);
    check("done pair 2", 32'(done), 32'h1);
    step(NOP);
    check("done pair ends", 32'(done), 32'h0);

    // Asynchronous reset during pending pulses.
    step(LD_A, 8'h33);
    step(LD_B, 8'h44);
    ControlBus = LD_OUT | DONE;
    @(posedge clk);
    #1;
    ControlBus = NOP;
    check("pulse dout_valid", 32'(dout_valid), 32'h1);
    check("pulse dout", 32'(dout), 32'h33);
    check("pulse done", 32'(done), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async reset done", 32'(done), 32'h0);
    check("async reset dout_valid", 32'(dout_valid), 32'h0);
    check("async reset dout", 32'(dout), 32'h0);
    check("async reset C", 32'(C), 32'h0);
    check("async reset Z", 32'(Z), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // The first edge after reset executes its word; A was cleared.
    readOut(8'h00);
    step(LD_A | LD_B, 8'h0A);
    readOut(8'h0A);
    check("Z after post-reset LD_B", 32'(Z), 32'h0);

    step(NOP);
    check("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_datapath.md
UP_DATAPATH -- requirements
Module: up_datapath

Interface
REQ-001 Parameter: WIDTH, default 8, data path width in bits for din, A, B and dout.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: ControlBus  input  7  microinstruction control word from the upstream microprogram controller.
REQ-005 Port: din  input  WIDTH  operand data bus, sampled on a load.
REQ-006 Port: Z  output  1  zero flag to the controller.
REQ-007 Port: C  output  1  sticky carry flag.
REQ-008 Port: dout  output  WIDTH  result register.
REQ-009 Port: dout_valid  output  1  one-cycle pulse marking a new dout.
REQ-010 Port: done  output  1  one-cycle registered end-of-program pulse.

Function
REQ-011 ControlBus bit map SHALL be:
- bit0 LD_A: load din into A.
- bit1 LD_B: load din into B.
- bit2 DEC_B: decrement B.
- bit3 ADD_AB: add B into A.
- bit4 CLR_A: clear A and C.
- bit5 LD_OUT: copy A to dout.
- bit6 DONE: end of program.
REQ-012 Next A SHALL follow fixed priority: CLR_A -> 0; else LD_A -> din; else ADD_AB -> (A+B) mod 2^WIDTH; else hold.
REQ-013 Next B SHALL follow: LD_B -> din; else DEC_B -> B-1 mod 2^WIDTH (0 wraps to all-ones); else hold.
REQ-014 Every operand on an edge SHALL be the pre-edge register value, e.g. ADD_AB+DEC_B together adds the old B.
REQ-015 C SHALL set to 1 on an edge where ADD_AB is effective (CLR_A and LD_A low) and the addition carries out of bit WIDTH-1; it SHALL clear on CLR_A and otherwise hold.
REQ-016 Z SHALL be combinational (B == 0) from the B register, so the controller samples the flag produced by the previous edge; no extra latency.
REQ-017 On LD_OUT, dout SHALL take the pre-edge A, and dout_valid SHALL be 1 for exactly the following cycle; otherwise dout holds and dout_valid is 0.
REQ-018 done SHALL be 1 for the cycle after an edge where DONE=1, and 0 otherwise; back-to-back DONE words give a continuous high.
REQ-019 All 128 ControlBus codes SHALL be legal; ControlBus = 0 is a no-op with all state held.
REQ-020 The result of an edge SHALL be visible one cycle after ControlBus presents the word, with no internal pipelining.

Reset
REQ-021 While reset_n = 0, the block SHALL hold A=0, B=0, C=0, dout=0, dout_valid=0 and done=0; Z therefore reads 1.
REQ-022 Reset assertion mid-program SHALL take effect immediately without waiting for clk, and SHALL discard any pending pulse.
REQ-023 The first edge after reset_n rises SHALL execute the ControlBus word present at that edge normally.

Structure
REQ-024 Shared package up_pkg SHALL hold the ControlBus bit-index constants, the control-word width (7) and the default WIDTH, for reuse by the controller and microcode tables.
REQ-025 Addition and carry generation SHALL live in one combinational sub-module, up_alu (inputs A, B; outputs sum, carry).
REQ-026 All other state SHALL be registers in up_datapath; the block SHALL contain no memories.

Verification
REQ-027 Reset: assert reset_n=0 asynchronously between edges -> all outputs 0 and Z=1 before the next edge.
REQ-028 Load and flag: din=3 with LD_B, then DEC_B x3 -> B=2,1,0; Z=1 only after the third edge; one more DEC_B -> B=0xFF, Z=0.
REQ-029 Multiply loop (WIDTH=8): load A=0, B=4, din=5; repeat ADD with a second operand path as the microprogram dictates, until Z; then LD_OUT -> dout=expected product and dout_valid high for exactly 1 cycle.
REQ-030 Carry and priority:
- A=0xF0, B=0x20, ADD_AB -> A=0x10, C=1.
- CLR_A+LD_A+ADD_AB together -> A=0, C=0.
- ADD_AB+DEC_B with B=2 -> A increases by 2, B=1.
REQ-031 Pulses: DONE for one cycle -> done high one cycle; DONE for two cycles -> done high two cycles; reset asserted during a done pulse -> done=0 immediately.
